// File: rtl/lfsr_axi_pkg.sv
// lfsr_axi_pkg: shared constants for the LFSR AXI-Lite command master.
// Holds the AXI response codes, the target register map and the master FSM states.
package lfsr_axi_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    localparam logic [7:0] REG_CTRL = 8'h0;
    localparam logic [7:0] REG_SEED = 8'h4;
    localparam logic [7:0] REG_TAPS = 8'h8;
    localparam logic [7:0] REG_DATA = 8'hC;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

endpackage

// File: rtl/lfsr_axi_master.sv
// lfsr_axi_master: turns single cmd_* requests into one AXI-Lite read or write
// and returns the outcome on rsp_*. One transaction outstanding; all outputs registered.
// Build macro LFSR_AXI_MASTER_TIMEOUT_EN adds a watchdog that ends a stalled
// transaction after TIMEOUT_CYCLES with response code 2'b11.
module lfsr_axi_master
    import lfsr_axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  awvalid_q, awvalid_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;

`ifdef LFSR_AXI_MASTER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
`endif

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = ST_WR_REQ;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_REQ;
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                // AW and W retire independently; a channel already done stays low.
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_axi_bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RD_REQ: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = RESP_OKAY;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef LFSR_AXI_MASTER_TIMEOUT_EN
        // A completion landing on the last allowed cycle wins over the watchdog.
        timer_d = '0;
        if (state_q inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_DATA}) begin
            timer_d = timer_q + TIMER_W'(1);
            if (timer_q == TIMER_LAST && state_d != ST_RESP) begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_resp_d  = RESP_TIMEOUT;
                rsp_rdata_d = '0;
                state_d     = ST_RESP;
            end
        end
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
`ifdef LFSR_AXI_MASTER_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
`ifdef LFSR_AXI_MASTER_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_lfsr_axi_master.sv
// tb_lfsr_axi_master: scoreboard bench for lfsr_axi_master with a randomized
// AXI-Lite register target (CTRL/SEED/TAPS/DATA) and a register-level reference model.
module tb_lfsr_axi_master;
    import lfsr_axi_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [3:0] m_axi_awaddr, m_axi_araddr;
    logic       m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [7:0] m_axi_wdata, m_axi_rdata;
    logic [1:0] m_axi_bresp;
    logic       m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic       m_axi_rvalid, m_axi_rready;

    lfsr_axi_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] rdata; logic [1:0] resp; } rsp_t;
    rsp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // bank 0: reference model driven by commands; bank 1: target driven by AXI traffic
    logic [7:0] bank [2][4];

    // knobs: fixed delays (-1 = random 0..3), channel holds, protocol-check enable
    int aw_fix = -1, w_fix = -1, b_fix = -1, ar_fix = -1, r_fix = -1, rr_fix = -1;
    bit hold_ar = 0, hold_r = 0, chk_en = 1;
    int last_wait;

    int unsigned aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0;
    logic [3:0] slv_awaddr, slv_araddr;
    logic [7:0] slv_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event expected one within bound", name);
    endtask

    function automatic int pick(input int f);
        return (f >= 0) ? f : int'($urandom_range(0, 3));
    endfunction

    // Target register behaviour: CTRL bit1 loads SEED into DATA, bit0 steps DATA once.
    task automatic reg_write(input int b, input logic [3:0] a, input logic [7:0] d,
                             output logic [1:0] resp);
        logic [7:0] v;
        if (a[1:0] != 2'b00) begin
            resp = RESP_SLVERR;
            return;
        end
        resp = RESP_OKAY;
        bank[b][a[3:2]] = d;
        if (a[3:2] == 2'd0) begin
            if (d[1]) bank[b][3] = bank[b][1];
            if (d[0]) begin
                v = bank[b][3];
                bank[b][3] = {v[6:0], ^(v & bank[b][2])};
            end
        end
    endtask

    function automatic logic [7:0] reg_read(input int b, input logic [3:0] a);
        return (a[1:0] == 2'b00) ? bank[b][a[3:2]] : 8'h00;
    endfunction

    function automatic logic [63:0] all_outs();
        return {31'd0, cmd_ready, rsp_valid, rsp_rdata, rsp_resp, m_axi_awaddr, m_axi_awvalid,
                m_axi_wdata, m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready};
    endfunction

    // AW channel of the target
    initial begin : aw_slave
        bit busy, hold; int cnt; logic [3:0] la;
        busy = 0; hold = 0; cnt = 0; la = '0; m_axi_awready = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin m_axi_awready = 0; busy = 0; hold = 0; continue; end
            if (hold && chk_en) begin
                chk("awvalid_held", m_axi_awvalid, 1);
                chk("awaddr_stable", m_axi_awaddr, la);
            end
            hold = 0; m_axi_awready = 0;
            if (m_axi_awvalid) begin
                if (!busy) begin busy = 1; cnt = pick(aw_fix); end
                if (cnt == 0) begin
                    m_axi_awready = 1; busy = 0; slv_awaddr = m_axi_awaddr; aw_hs_n++;
                end else begin
                    cnt--; hold = 1; la = m_axi_awaddr;
                end
            end else busy = 0;
        end
    end

    // W channel of the target
    initial begin : w_slave
        bit busy, hold; int cnt; logic [7:0] ld;
        busy = 0; hold = 0; cnt = 0; ld = '0; m_axi_wready = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin m_axi_wready = 0; busy = 0; hold = 0; continue; end
            if (hold && chk_en) begin
                chk("wvalid_held", m_axi_wvalid, 1);
                chk("wdata_stable", m_axi_wdata, ld);
            end
            hold = 0; m_axi_wready = 0;
            if (m_axi_wvalid) begin
                if (!busy) begin busy = 1; cnt = pick(w_fix); end
                if (cnt == 0) begin
                    m_axi_wready = 1; busy = 0; slv_wdata = m_axi_wdata; w_hs_n++;
                end else begin
                    cnt--; hold = 1; ld = m_axi_wdata;
                end
            end else busy = 0;
        end
    end

    // B channel: commits the write once both AW and W have completed
    initial begin : b_slave
        bit busy, hs; int cnt; int unsigned aw_used, w_used; logic [1:0] br;
        busy = 0; hs = 0; cnt = 0; aw_used = 0; w_used = 0; br = '0;
        m_axi_bvalid = 0; m_axi_bresp = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_axi_bvalid = 0; busy = 0; hs = 0; aw_used = aw_hs_n; w_used = w_hs_n;
                continue;
            end
            if (m_axi_bready) chk("bready_after_aw_w", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
            if (hs) begin m_axi_bvalid = 0; hs = 0; end
            if (!busy && aw_hs_n != aw_used && w_hs_n != w_used && !m_axi_awvalid && !m_axi_wvalid) begin
                aw_used++; w_used++;
                reg_write(1, slv_awaddr, slv_wdata, br);
                busy = 1; cnt = pick(b_fix);
            end
            if (busy) begin
                if (cnt == 0) begin
                    m_axi_bvalid = 1; m_axi_bresp = br;
                    if (m_axi_bready) begin hs = 1; busy = 0; end
                end else cnt--;
            end
        end
    end

    // AR channel of the target
    initial begin : ar_slave
        bit busy, hold; int cnt; logic [3:0] la;
        busy = 0; hold = 0; cnt = 0; la = '0; m_axi_arready = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin m_axi_arready = 0; busy = 0; hold = 0; continue; end
            if (hold && chk_en) begin
                chk("arvalid_held", m_axi_arvalid, 1);
                chk("araddr_stable", m_axi_araddr, la);
            end
            hold = 0; m_axi_arready = 0;
            if (m_axi_arvalid) begin
                if (!busy) begin busy = 1; cnt = pick(ar_fix); end
                if (!hold_ar && cnt == 0) begin
                    m_axi_arready = 1; busy = 0; slv_araddr = m_axi_araddr; ar_hs_n++;
                end else begin
                    if (cnt > 0) cnt--;
                    hold = 1; la = m_axi_araddr;
                end
            end else busy = 0;
        end
    end

    // R channel of the target
    initial begin : r_slave
        bit busy, hs; int cnt; int unsigned ar_used; logic [7:0] rd;
        busy = 0; hs = 0; cnt = 0; ar_used = 0; rd = '0;
        m_axi_rvalid = 0; m_axi_rdata = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin m_axi_rvalid = 0; busy = 0; hs = 0; ar_used = ar_hs_n; continue; end
            if (m_axi_rready) chk("rready_after_ar", m_axi_arvalid, 0);
            if (hs) begin m_axi_rvalid = 0; hs = 0; end
            if (!busy && ar_hs_n != ar_used && !m_axi_arvalid) begin
                ar_used++;
                rd = reg_read(1, slv_araddr);
                busy = 1; cnt = pick(r_fix);
            end
            if (busy && !hold_r) begin
                if (cnt == 0) begin
                    m_axi_rvalid = 1; m_axi_rdata = rd;
                    if (m_axi_rready) begin hs = 1; busy = 0; end
                end else cnt--;
            end
        end
    end

    // Response side: drives rsp_ready, checks stability and pops the scoreboard
    initial begin : rsp_side
        bit have_prev, fresh; int stall, wait_n; logic [7:0] pr; logic [1:0] pp; rsp_t e;
        have_prev = 0; fresh = 1; stall = 0; wait_n = 0; pr = '0; pp = '0;
        rsp_ready = 0; last_wait = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin rsp_ready = 0; have_prev = 0; fresh = 1; wait_n = 0; continue; end
            if (rsp_valid) begin
                chk("cmd_ready_low_while_rsp", cmd_ready, 0);
                if (have_prev) begin
                    chk("rsp_rdata_stable", rsp_rdata, pr);
                    chk("rsp_resp_stable", rsp_resp, pp);
                end
                if (fresh) begin stall = pick(rr_fix); fresh = 0; wait_n = 0; end
                if (stall > 0) begin rsp_ready = 0; stall--; wait_n++; end
                else rsp_ready = 1;
                if (rsp_ready) begin
                    if (exp_q.size() == 0) fail_evt("rsp_without_command");
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_resp", rsp_resp, e.resp);
                    end
                    last_wait = wait_n; have_prev = 0; fresh = 1;
                end else begin
                    have_prev = 1; pr = rsp_rdata; pp = rsp_resp;
                end
            end else begin
                if (have_prev) chk("rsp_valid_held", rsp_valid, 1);
                have_prev = 0;
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic issue(input bit wr, input logic [3:0] a, input logic [7:0] d, input bit tmo);
        int n; rsp_t e; logic [1:0] r;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        if (!cmd_ready) begin fail_evt("cmd_accept"); cmd_valid = 0; return; end
        if (tmo) begin
            e.rdata = 8'h00; e.resp = RESP_TIMEOUT;
        end else if (wr) begin
            reg_write(0, a, d, r); e.rdata = 8'h00; e.resp = r;
        end else begin
            e.rdata = reg_read(0, a); e.resp = RESP_OKAY;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 4'($urandom); cmd_wdata = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 2000) begin @(negedge clk); n++; end
        if (exp_q.size() != 0 || !cmd_ready) fail_evt("drain");
    endtask

    initial begin : main
        int awc, wc, first_b, n;
        logic [3:0] a;
        for (int b = 0; b < 2; b++) for (int i = 0; i < 4; i++) bank[b][i] = 8'h00;
        resetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        @(posedge clk); #1 resetn = 1;
        @(posedge clk);
        @(negedge clk);
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // write SEED then read it back; write to unmapped offset
        issue(1, 4'h4, 8'h5A, 0);
        issue(0, 4'h4, 8'h00, 0);
        issue(1, 4'h2, 8'h77, 0);
        // seed load through CTRL, then read DATA
        issue(1, 4'h4, 8'h01, 0);
        issue(1, 4'h0, 8'h02, 0);
        issue(1, 4'h0, 8'h00, 0);
        issue(0, 4'hC, 8'h00, 0);
        drain();

        // W accepted immediately, AW delayed 3 cycles
        aw_fix = 3; w_fix = 0; b_fix = 0;
        issue(1, 4'h8, 8'hC3, 0);
        awc = 0; wc = 0; first_b = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_axi_awvalid) awc++;
            if (m_axi_wvalid) wc++;
            if (m_axi_bready && first_b < 0) first_b = i;
        end
        chk("wvalid_cycles", wc, 1);
        chk("awvalid_cycles", awc, 4);
        chk("bready_first_cycle", first_b, 4);
        aw_fix = -1; w_fix = -1; b_fix = -1;
        drain();

        // response back-pressure for 5 cycles with a command already waiting
        rr_fix = 5;
        issue(0, 4'h8, 8'h00, 0);
        issue(0, 4'hC, 8'h00, 0);
        drain();
        chk("rsp_stall_cycles", last_wait, 5);
        rr_fix = -1;

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 1) == 1) a = {2'($urandom_range(0, 3)), 2'b00};
            else a = 4'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), a, 8'($urandom), 0);
        end
        drain();

        // reset while waiting for read data abandons the transaction
        hold_r = 1;
        issue(0, 4'h4, 8'h00, 0);
        n = 0;
        while (!m_axi_rready && n < 100) begin @(negedge clk); n++; end
        if (!m_axi_rready) fail_evt("reach_rd_data");
        @(posedge clk); #1 resetn = 0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_in_rd_data_outputs", all_outs(), 64'd0);
        @(posedge clk); #1 resetn = 1;
        hold_r = 0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("outputs_after_release", all_outs(), 64'h1_0000_0000 >> 0 & 64'h0 | {31'd0, 1'b1, 32'd0});
        issue(0, 4'h4, 8'h00, 0);
        drain();

`ifdef LFSR_AXI_MASTER_TIMEOUT_EN
        // AR never accepted: watchdog ends the read
        chk_en = 0; hold_ar = 1;
        issue(0, 4'h4, 8'h00, 1);
        n = 0;
        while (n < 200) begin @(negedge clk); if (rsp_valid) break; n++; end
        chk("timeout_latency", n, 64);
        drain();
        hold_ar = 0; chk_en = 1;
`else
        // without the watchdog a stalled read waits indefinitely, then completes
        hold_ar = 1;
        issue(0, 4'h4, 8'h00, 0);
        repeat (150) @(negedge clk);
        chk("no_rsp_while_ar_stalled", rsp_valid, 0);
        chk("arvalid_still_high", m_axi_arvalid, 1);
        hold_ar = 0;
        drain();
`endif
        issue(0, 4'hC, 8'h00, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: got no completion expected summary before bound");
        $fatal(1, "bench watchdog expired");
    end

endmodule
